// File: rtl/itcm_port_arbiter_pkg.sv
// Shared types for the ITCM port arbiter: response-owner encoding and
// starvation counter sizing.
package itcm_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DS   = 2'd2,
        OWN_DBG  = 2'd3
    } owner_e;

    localparam int unsigned STARVE_CW = 4;
    localparam logic [3:0]  BE_FULL   = 4'hF;

endpackage

// File: rtl/itcm_starve_cnt.sv
// Saturating counter tracking consecutive cycles the data side was denied.
module itcm_starve_cnt
    import itcm_port_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic cpu_clk,
    input  logic cpu_rstn,
    input  logic inc,
    input  logic clr,
    output logic full
);

    logic [STARVE_CW-1:0] cnt;

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != STARVE_CW'(LIMIT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign full = (cnt == STARVE_CW'(LIMIT));

endmodule

// File: rtl/itcm_port_arbiter.sv
// Arbitrates IF, DS and DBG onto the single-port ITCM SRAM and routes each
// one-cycle read response back to the requester that issued it.
module itcm_port_arbiter
    import itcm_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEM_AW       = 14,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rstn,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_flush,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  ds_req,
    input  logic                  ds_we,
    input  logic [3:0]            ds_be,
    input  logic [ADDR_WIDTH-1:0] ds_addr,
    input  logic [DATA_WIDTH-1:0] ds_wdata,
    output logic                  ds_gnt,
    output logic                  ds_rvalid,
    output logic [DATA_WIDTH-1:0] ds_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    owner_e owner;
    owner_e owner_nxt;
    logic   starve_full;

    // Byte-offset and out-of-ITCM address bits are resolved upstream.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0],  if_addr[ADDR_WIDTH-1:MEM_AW+2],
                                ds_addr[1:0],  ds_addr[ADDR_WIDTH-1:MEM_AW+2],
                                dbg_addr[1:0], dbg_addr[ADDR_WIDTH-1:MEM_AW+2]};

    itcm_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .cpu_clk  (cpu_clk),
        .cpu_rstn (cpu_rstn),
        .inc      (ds_req && !ds_gnt && !dbg_gnt),
        .clr      (ds_gnt),
        .full     (starve_full)
    );

    // Grants are gated by reset so nothing reaches the SRAM while held in reset.
    always_comb begin
        if_gnt  = 1'b0;
        ds_gnt  = 1'b0;
        dbg_gnt = 1'b0;
        if (cpu_rstn) begin
            if (dbg_req)                    dbg_gnt = 1'b1;
            else if (ds_req && starve_full) ds_gnt  = 1'b1;
            else if (if_req)                if_gnt  = 1'b1;
            else if (ds_req)                ds_gnt  = 1'b1;
        end
    end

    always_comb begin
        mem_cs    = if_gnt | ds_gnt | dbg_gnt;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        owner_nxt = OWN_NONE;
        if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_be    = BE_FULL;
            mem_addr  = dbg_addr[MEM_AW+1:2];
            mem_wdata = dbg_wdata;
            owner_nxt = dbg_we ? OWN_NONE : OWN_DBG;
        end else if (ds_gnt) begin
            mem_we    = ds_we;
            mem_be    = ds_be;
            mem_addr  = ds_addr[MEM_AW+1:2];
            mem_wdata = ds_wdata;
            owner_nxt = ds_we ? OWN_NONE : OWN_DS;
        end else if (if_gnt) begin
            mem_be    = BE_FULL;
            mem_addr  = if_addr[MEM_AW+1:2];
            owner_nxt = OWN_IF;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) owner <= OWN_NONE;
        else           owner <= owner_nxt;
    end

    always_comb begin
        if_rvalid  = (owner == OWN_IF) && !if_flush;
        ds_rvalid  = (owner == OWN_DS);
        dbg_rvalid = (owner == OWN_DBG);
        if_rdata   = (owner == OWN_IF)  ? mem_rdata : '0;
        ds_rdata   = (owner == OWN_DS)  ? mem_rdata : '0;
        dbg_rdata  = (owner == OWN_DBG) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_itcm_port_arbiter.sv
// Scoreboard bench for itcm_port_arbiter with a behavioural single-port SRAM.
module tb_itcm_port_arbiter;

    logic        cpu_clk = 1'b0;
    logic        cpu_rstn;
    logic        if_req, if_flush, ds_req, ds_we, dbg_req, dbg_we;
    logic [31:0] if_addr, ds_addr, ds_wdata, dbg_addr, dbg_wdata;
    logic [3:0]  ds_be;
    logic        if_gnt, if_rvalid, ds_gnt, ds_rvalid, dbg_gnt, dbg_rvalid;
    logic [31:0] if_rdata, ds_rdata, dbg_rdata;
    logic        mem_cs, mem_we;
    logic [3:0]  mem_be;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    int n_vec = 0;
    int n_err = 0;
    int unsigned cyc = 0;

    typedef struct {
        int unsigned due;
        logic [2:0]  mask;  // {if, ds, dbg}
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    logic [31:0] sram [0:255];

    itcm_port_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .MEM_AW       (14),
        .STARVE_LIMIT (4)
    ) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rstn   (cpu_rstn),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ds_req     (ds_req),
        .ds_we      (ds_we),
        .ds_be      (ds_be),
        .ds_addr    (ds_addr),
        .ds_wdata   (ds_wdata),
        .ds_gnt     (ds_gnt),
        .ds_rvalid  (ds_rvalid),
        .ds_rdata   (ds_rdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 cpu_clk = ~cpu_clk;

    always @(posedge cpu_clk) cyc <= cyc + 1;

    always @(posedge cpu_clk) begin
        if (mem_cs) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr[7:0]];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge cpu_clk) begin : monitor
        exp_t        e;
        logic [2:0]  vmask;
        vmask = {if_rvalid, ds_rvalid, dbg_rvalid};
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("rvalid_mask", {29'd0, vmask}, {29'd0, e.mask});
            case (e.mask)
                3'b100:  check("if_rdata",  if_rdata,  e.data);
                3'b010:  check("ds_rdata",  ds_rdata,  e.data);
                3'b001:  check("dbg_rdata", dbg_rdata, e.data);
                default: ;
            endcase
        end else if (vmask != 3'b000) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_rvalid: got %b, expected 000 (cycle %0d)", vmask, cyc);
        end
    end

    task automatic idle_inputs();
        if_req = 0; if_flush = 0; ds_req = 0; ds_we = 0; dbg_req = 0; dbg_we = 0;
        if_addr = '0; ds_addr = '0; ds_wdata = '0; dbg_addr = '0; dbg_wdata = '0;
        ds_be = 4'hF;
    endtask

    task automatic next_cycle();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic expect_rsp(input logic [2:0] mask, input logic [31:0] data);
        exp_t e;
        e.due  = cyc + 1;
        e.mask = mask;
        e.data = data;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] gnts();
        return {29'd0, if_gnt, ds_gnt, dbg_gnt};
    endfunction

    logic [31:0] t3_if_addr [6] = '{32'h110, 32'h114, 32'h118, 32'h11C, 32'h120, 32'h120};
    logic [2:0]  t3_gnt     [6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b100};
    logic [31:0] t3_data    [6] = '{32'hC0DE0044, 32'hC0DE0045, 32'hC0DE0046,
                                    32'hC0DE0047, 32'hC0DE0080, 32'hC0DE0048};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) sram[i] = 32'hC0DE0000 | i;
        sram[8'h40] = 32'h00008067;

        // Reset held with every requester active
        cpu_rstn = 0;
        idle_inputs();
        if_req = 1; ds_req = 1; dbg_req = 1;
        repeat (3) next_cycle();
        check("rst_gnts",   gnts(), 32'd0);
        check("rst_mem_cs", {31'd0, mem_cs}, 32'd0);
        check("rst_rvalid", {29'd0, if_rvalid, ds_rvalid, dbg_rvalid}, 32'd0);
        check("rst_rdata",  if_rdata | ds_rdata | dbg_rdata, 32'd0);
        idle_inputs();
        next_cycle();
        cpu_rstn = 1;
        repeat (3) next_cycle();

        // Basic fetch
        if_req = 1; if_addr = 32'h100;
        #1;
        check("t2_gnts",     gnts(), 32'b100);
        check("t2_mem_addr", {18'd0, mem_addr}, 32'h40);
        check("t2_mem_cs",   {31'd0, mem_cs}, 32'd1);
        check("t2_mem_be",   {28'd0, mem_be}, 32'hF);
        expect_rsp(3'b100, 32'h00008067);
        next_cycle();
        idle_inputs();
        next_cycle();

        // Starvation override
        for (int i = 0; i < 6; i++) begin
            if_req = 1; ds_req = 1; ds_we = 0; ds_addr = 32'h200;
            if_addr = t3_if_addr[i];
            #1;
            check("t3_gnts", gnts(), {29'd0, t3_gnt[i]});
            expect_rsp(t3_gnt[i] == 3'b010 ? 3'b010 : 3'b100, t3_data[i]);
            next_cycle();
        end
        idle_inputs();
        next_cycle();

        // Debug wins over everything
        dbg_req = 1; dbg_addr = 32'h300; if_req = 1; if_addr = 32'h130;
        ds_req = 1; ds_addr = 32'h204;
        #1;
        check("t4_gnts",     gnts(), 32'b001);
        check("t4_mem_addr", {18'd0, mem_addr}, 32'hC0);
        expect_rsp(3'b001, 32'hC0DE00C0);
        next_cycle();
        idle_inputs();
        next_cycle();

        // Flush kills the pending fetch response; same-cycle fetch still proceeds
        if_req = 1; if_addr = 32'h104;
        #1;
        check("t5_gnt_a", gnts(), 32'b100);
        expect_rsp(3'b000, 32'd0);
        next_cycle();
        if_flush = 1; if_addr = 32'h108;
        #1;
        check("t5_gnt_b", gnts(), 32'b100);
        expect_rsp(3'b100, 32'hC0DE0042);
        next_cycle();
        idle_inputs();
        next_cycle();

        // DS partial write, then read back
        ds_req = 1; ds_we = 1; ds_be = 4'b0011; ds_addr = 32'h8; ds_wdata = 32'hAABBCCDD;
        #1;
        check("t6_gnts",      gnts(), 32'b010);
        check("t6_mem_we",    {31'd0, mem_we}, 32'd1);
        check("t6_mem_be",    {28'd0, mem_be}, 32'b0011);
        check("t6_mem_addr",  {18'd0, mem_addr}, 32'd2);
        check("t6_mem_wdata", mem_wdata, 32'hAABBCCDD);
        expect_rsp(3'b000, 32'd0);
        next_cycle();
        ds_we = 0; ds_be = 4'hF;
        #1;
        expect_rsp(3'b010, 32'hC0DECCDD);
        next_cycle();

        // DBG full-word write, then read back
        idle_inputs();
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'hC; dbg_wdata = 32'h12345678;
        #1;
        check("t7_mem_we", {31'd0, mem_we}, 32'd1);
        check("t7_mem_be", {28'd0, mem_be}, 32'hF);
        expect_rsp(3'b000, 32'd0);
        next_cycle();
        dbg_we = 0;
        #1;
        expect_rsp(3'b001, 32'h12345678);
        next_cycle();
        idle_inputs();

        repeat (4) next_cycle();
        check("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
